// File: rtl/msrv32_pkg.sv
// Shared constants and helpers for the msrv32 front end.
package msrv32_pkg;

  localparam int          XLEN             = 32;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/msrv32_sync_fifo.sv
// Small synchronous FIFO with clear; head word is visible combinationally.
module msrv32_sync_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/msrv32_instr_fetch_unit.sv
// RV32I fetch front end: credit-limited imem requests, in-order response queue,
// stale-response dropping after redirects, NOP when nothing valid is available.
module msrv32_instr_fetch_unit
  import msrv32_pkg::*;
#(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  input  logic        redirect_in,
  input  logic [31:0] redirect_pc_in,
  input  logic        ready_in,
  output logic        imem_req_out,
  output logic [31:0] imem_addr_out,
  input  logic        imem_gnt_in,
  input  logic        imem_rvalid_in,
  input  logic [31:0] imem_rdata_in,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc_out,
  output logic        instr_valid_out,
  output logic        flush_out
);

  localparam int             CW           = $clog2(DEPTH + 1);
  localparam logic [CW:0]    DEPTH_CREDIT = (CW + 1)'(DEPTH);

  logic [XLEN-1:0]   pc;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     drop;
  logic [CW-1:0]     out_next;
  logic [CW-1:0]     drop_next;
  logic [CW:0]       credit_used;
  logic              grant;
  logic              rsp_seen;
  logic              live_rsp;

  logic [2*XLEN-1:0] q_head;
  logic [CW-1:0]     q_count;
  logic              q_empty;
  logic              q_full;
  logic [XLEN-1:0]   pcq_head;
  logic [CW-1:0]     pcq_count;
  logic              pcq_empty;
  logic              pcq_full;
  logic              unused_sink;

  // Outstanding counts every request in flight, stale or live; drop is the
  // stale subset still to come back, so the credit check covers both.
  assign credit_used   = {1'b0, q_count} + {1'b0, outstanding};
  assign imem_req_out  = !ms_riscv32_mp_rst_in && (credit_used < DEPTH_CREDIT);
  assign imem_addr_out = pc;
  assign grant         = imem_req_out && imem_gnt_in;
  assign rsp_seen      = imem_rvalid_in && (outstanding != '0);
  assign live_rsp      = rsp_seen && !redirect_in && (drop == '0);

  assign instr_valid_out = !q_empty && !redirect_in;
  assign instr_out       = instr_valid_out ? q_head[XLEN-1:0]      : NOP_INSTR;
  assign instr_pc_out    = instr_valid_out ? q_head[2*XLEN-1:XLEN] : '0;

  assign unused_sink = &{1'b0, q_full, pcq_count, pcq_empty, pcq_full, redirect_pc_in[1:0]};

  // PCs of live granted requests, matched in order against returning words.
  msrv32_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (XLEN)
  ) u_pc_fifo (
    .clk       (ms_riscv32_mp_clk_in),
    .rst       (ms_riscv32_mp_rst_in),
    .clear     (redirect_in),
    .push      (grant && !redirect_in),
    .push_data (pc),
    .pop       (live_rsp),
    .head_data (pcq_head),
    .count     (pcq_count),
    .empty     (pcq_empty),
    .full      (pcq_full)
  );

  msrv32_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2 * XLEN)
  ) u_instr_fifo (
    .clk       (ms_riscv32_mp_clk_in),
    .rst       (ms_riscv32_mp_rst_in),
    .clear     (redirect_in),
    .push      (live_rsp),
    .push_data ({pcq_head, imem_rdata_in}),
    .pop       (instr_valid_out && ready_in),
    .head_data (q_head),
    .count     (q_count),
    .empty     (q_empty),
    .full      (q_full)
  );

  always_comb begin
    out_next = outstanding;
    if (grant && !rsp_seen)      out_next = outstanding + CW'(1);
    else if (!grant && rsp_seen) out_next = outstanding - CW'(1);
    drop_next = drop;
    if (redirect_in)                     drop_next = out_next;
    else if (rsp_seen && (drop != '0))   drop_next = drop - CW'(1);
  end

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      pc          <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
      flush_out   <= 1'b0;
    end else begin
      if (redirect_in)  pc <= word_align(redirect_pc_in);
      else if (grant)   pc <= pc + 32'd4;
      outstanding <= out_next;
      drop        <= drop_next;
      flush_out   <= redirect_in;
    end
  end

endmodule
